clk_div_ratio_ctrl: RTL and testbench
=====================================

Name: clk_div_ratio_ctrl

Overview:
- Upstream control stage for the integer clock divider: owns the divide-ratio bus feeding the divider's ratio input.
- Accepts ratio change requests over a valid/ready handshake and validates them.
- Applies an accepted ratio only on a divider period boundary, so the divider never sees its ratio shrink below its running count mid-period.
- Keeps a shadow period counter in lock-step with the divider's internal counter; both run on the same clock and the same reset.

Parameters:
- RATIO_W, 8: width of the ratio request and ratio output buses.
- DEFAULT_RATIO, 2: ratio driven from reset. Must be within 1..MAX_RATIO.
- MAX_RATIO, 255: largest accepted ratio; requests above it are rejected.

Ports:
- i_clk  input  1  source clock; same clock as the divider.
- i_rst_n  input  1  asynchronous active-low reset; same net as the divider's reset.
- i_req_valid  input  1  a ratio change request is present.
- i_req_ratio  input  RATIO_W  requested divide ratio, unsigned.
- o_req_ready  output  1  the controller can accept a request this cycle.
- o_div_ratio  output  RATIO_W  ratio driven to the divider; zero-extended at the divider boundary.
- o_div_en  output  1  1 = use the divided clock; 0 = ratio is 1, so the downstream mux selects the source clock.
- o_update  output  1  one-cycle pulse in the cycle after a new ratio takes effect.
- o_err  output  1  one-cycle pulse for a rejected request (ratio 0 or above MAX_RATIO).
- o_phase  output  RATIO_W  shadow period counter, for monitoring.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - o_div_ratio = DEFAULT_RATIO.
  - o_div_en = (DEFAULT_RATIO != 1).
  - o_phase = 0.
  - o_req_ready = 1.
  - o_update = 0, o_err = 0.
  - State = IDLE; pending register = 0.
- Shadow counter:
  - Every cycle: if o_phase == o_div_ratio-1, then o_phase <= 0; else o_phase <= o_phase+1.
  - This matches the divider's own counter exactly.
  - Boundary = any cycle with o_phase == o_div_ratio-1.
- State machine has two states, IDLE and PEND. o_req_ready = (state == IDLE), driven combinationally from state.
- Request acceptance (handshake: i_req_valid & o_req_ready, sampled at the rising edge):
  - Request is 0 or above MAX_RATIO: o_err = 1 for the next cycle only; state stays IDLE; no ratio change.
  - Request equals the current o_div_ratio: accepted with no pending update; state stays IDLE; no o_update pulse.
  - Otherwise: pending <= i_req_ratio; state <= PEND.
- PEND state:
  - o_req_ready = 0; i_req_valid is ignored and the requester must hold or retry.
  - On a boundary edge:
    - o_div_ratio <= pending.
    - o_div_en <= (pending != 1).
    - o_phase <= 0.
    - o_update pulses for 1 cycle.
    - state <= IDLE.
- Latency from acceptance to effect: from 1 cycle up to the old ratio in cycles.
  - If acceptance itself lands on a boundary edge, the ratio is not applied on that same edge; it waits for the next boundary.
  - This gives a worst case of old ratio + 0 cycles after entering PEND.
- Divider alignment: on the boundary edge the divider still sees the old ratio and wraps its counter to 0. From the next cycle both counters restart at 0 under the new ratio.
- Ratio 1: the boundary occurs every cycle, so a PEND entered from ratio 1 resolves on the next edge.
- Back-to-back requests: the earliest a new request can be accepted is the cycle o_update is high, because ready returns with IDLE.
- Reset mid-PEND: the pending request is discarded and all outputs return to their reset values immediately (asynchronous).
- Arithmetic: all comparisons are unsigned RATIO_W-bit. o_div_ratio-1 never underflows, because 0 is never loaded.

Test Plan:
- Reset, then idle 10 cycles → o_div_ratio = 2, o_div_en = 1, and o_phase toggles 0,1,0,1.
- At ratio 2, request 5 accepted at o_phase = 0 → ready drops; at the next edge with o_phase = 1, o_div_ratio becomes 5 and o_update pulses; o_phase then runs 0..4.
- At ratio 8, request 3 accepted at o_phase = 2 → held for 5 more cycles until o_phase = 7, then the ratio becomes 3. o_phase must never exceed 7 and never jumps to 3..7 under the new ratio.
- Request 0, then request 300 with RATIO_W = 9, MAX_RATIO = 255 → o_err pulses once for each request; o_div_ratio is unchanged; ready stays 1.
- Request 1 from ratio 4 → at the boundary, o_div_en = 0 and o_phase stays 0. Then request 4 → applied on the next edge and o_div_en = 1.
- Request 6 from ratio 4, with reset asserted during PEND → o_div_ratio = 2 and ready = 1 immediately; ratio 6 is never applied after reset release.

Source files
------------

// File: rtl/clk_div_ratio_ctrl.sv
// clk_div_ratio_ctrl: validates ratio requests and applies them on divider period boundaries
module clk_div_ratio_ctrl #(
  parameter int unsigned RATIO_W       = 8,
  parameter int unsigned DEFAULT_RATIO = 2,
  parameter int unsigned MAX_RATIO     = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  input  logic [RATIO_W-1:0] i_req_ratio,
  output logic               o_req_ready,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_div_en,
  output logic               o_update,
  output logic               o_err,
  output logic [RATIO_W-1:0] o_phase
);
  typedef enum logic {IDLE, PEND} state_t;
  localparam logic [RATIO_W-1:0] L_DEF = RATIO_W'(DEFAULT_RATIO);
  localparam logic [RATIO_W-1:0] L_ONE = RATIO_W'(1);
  state_t             r_state;
  logic [RATIO_W-1:0] r_ratio;
  logic [RATIO_W-1:0] r_pending;
  logic [RATIO_W-1:0] r_phase;
  logic               r_en;
  logic               r_update;
  logic               r_err;
  logic               w_boundary;
  logic               w_bad;
  // boundary mirrors the divider's wrap condition; bad flags out-of-range requests
  assign w_boundary = r_phase == r_ratio - L_ONE;
  assign w_bad      = (i_req_ratio == '0) || (32'(i_req_ratio) > 32'(MAX_RATIO));
  // shadow counter, request acceptance and boundary-aligned ratio switch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_ratio   <= L_DEF;
      r_en      <= (DEFAULT_RATIO != 1);
      r_phase   <= '0;
      r_update  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_err    <= 1'b0;
      r_phase  <= w_boundary ? '0 : r_phase + L_ONE;
      if (r_state == IDLE) begin
        if (i_req_valid && w_bad)
          r_err <= 1'b1;
        else if (i_req_valid && i_req_ratio != r_ratio) begin
          r_pending <= i_req_ratio;
          r_state   <= PEND;
        end
      end else if (w_boundary) begin
        r_ratio  <= r_pending;
        r_en     <= r_pending != L_ONE;
        r_update <= 1'b1;
        r_state  <= IDLE;
      end
    end
  end
  assign o_req_ready = r_state == IDLE;
  assign o_div_ratio = r_ratio;
  assign o_div_en    = r_en;
  assign o_update    = r_update;
  assign o_err       = r_err;
  assign o_phase     = r_phase;
endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// tb_clk_div_ratio_ctrl: directed table plus randomized checks against a timeline model
module tb_clk_div_ratio_ctrl;
  localparam int W = 9;
  typedef struct {
    bit v;
    int r;
    int ratio;
    bit en;
    int phase;
    bit ready;
    bit upd;
    bit err;
  } row_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_ratio = '0;
  logic         req_ready;
  logic [W-1:0] div_ratio;
  logic         div_en;
  logic         update;
  logic         err;
  logic [W-1:0] phase;
  int n_err = 0;
  int n_chk = 0;
  row_t tbl[$];
  int m_ratio, m_start, m_cyc, m_pval;
  bit m_pend, m_upd, m_err;

  clk_div_ratio_ctrl #(.RATIO_W(W), .DEFAULT_RATIO(2), .MAX_RATIO(255)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_ratio(req_ratio),
    .o_req_ready(req_ready), .o_div_ratio(div_ratio), .o_div_en(div_en),
    .o_update(update), .o_err(err), .o_phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ra, input bit en, input int ph,
                         input bit rdy, input bit up, input bit er);
    chk({tag, " ratio"}, int'(div_ratio), ra);
    chk({tag, " en"}, int'(div_en), int'(en));
    chk({tag, " phase"}, int'(phase), ph);
    chk({tag, " ready"}, int'(req_ready), int'(rdy));
    chk({tag, " update"}, int'(update), int'(up));
    chk({tag, " err"}, int'(err), int'(er));
  endtask

  task automatic add(input bit v, input int r, input int ra, input bit en, input int ph,
                     input bit rdy, input bit up, input bit er);
    tbl.push_back('{v, r, ra, en, ph, rdy, up, er});
  endtask

  // Model: the phase is time since the current period train started, modulo the ratio.
  function automatic int m_phase();
    return (m_cyc - m_start) % m_ratio;
  endfunction

  task automatic m_reset();
    m_ratio = 2; m_start = 0; m_cyc = 0; m_pend = 0; m_pval = 0; m_upd = 0; m_err = 0;
  endtask

  task automatic m_step(input bit v, input int r);
    bit bnd;
    bnd = m_phase() == m_ratio - 1;
    m_upd = 0;
    m_err = 0;
    if (m_pend) begin
      if (bnd) begin
        m_ratio = m_pval;
        m_start = m_cyc + 1;
        m_upd = 1;
        m_pend = 0;
      end
    end else if (v) begin
      if (r == 0 || r > 255) m_err = 1;
      else if (r != m_ratio) begin
        m_pend = 1;
        m_pval = r;
      end
    end
    m_cyc++;
  endtask

  task automatic cyc(input bit v, input int r);
    req_valid = v;
    req_ratio = W'(r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 1; i <= 10; i++) add(0, 0, 2, 1, i % 2, 1, 0, 0);
    add(1, 5, 2, 1, 1, 0, 0, 0);
    add(0, 0, 5, 1, 0, 1, 1, 0);
    for (int p = 1; p <= 4; p++) add(0, 0, 5, 1, p, 1, 0, 0);
    add(0, 0, 5, 1, 0, 1, 0, 0);
    add(1, 8, 5, 1, 1, 0, 0, 0);
    for (int p = 2; p <= 4; p++) add(0, 0, 5, 1, p, 0, 0, 0);
    add(0, 0, 8, 1, 0, 1, 1, 0);
    add(0, 0, 8, 1, 1, 1, 0, 0);
    add(0, 0, 8, 1, 2, 1, 0, 0);
    add(1, 3, 8, 1, 3, 0, 0, 0);
    for (int p = 4; p <= 7; p++) add(0, 0, 8, 1, p, 0, 0, 0);
    add(0, 0, 3, 1, 0, 1, 1, 0);
    add(0, 0, 3, 1, 1, 1, 0, 0);
    add(0, 0, 3, 1, 2, 1, 0, 0);
    add(0, 0, 3, 1, 0, 1, 0, 0);
    add(1, 0, 3, 1, 1, 1, 0, 1);
    add(0, 0, 3, 1, 2, 1, 0, 0);
    add(1, 300, 3, 1, 0, 1, 0, 1);
    add(0, 0, 3, 1, 1, 1, 0, 0);
    add(1, 4, 3, 1, 2, 0, 0, 0);
    add(0, 0, 4, 1, 0, 1, 1, 0);
    for (int p = 1; p <= 3; p++) add(0, 0, 4, 1, p, 1, 0, 0);
    add(0, 0, 4, 1, 0, 1, 0, 0);
    add(1, 1, 4, 1, 1, 0, 0, 0);
    add(0, 0, 4, 1, 2, 0, 0, 0);
    add(0, 0, 4, 1, 3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0);
    add(1, 4, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4, 1, 0, 1, 1, 0);
    add(0, 0, 4, 1, 1, 1, 0, 0);
    add(1, 4, 4, 1, 2, 1, 0, 0);
    add(1, 6, 4, 1, 3, 0, 0, 0);

    #12;
    chk_all("reset", 2, 1, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].r);
      chk_all($sformatf("row%0d", i), tbl[i].ratio, tbl[i].en, tbl[i].phase,
              tbl[i].ready, tbl[i].upd, tbl[i].err);
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2, 1, 0, 1, 0, 0);
    cyc(0, 0);
    cyc(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0);
      chk_all($sformatf("post_rst%0d", i), 2, 1, i % 2, 1, 0, 0);
    end

    rst_n = 1'b0;
    #1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit v;
      int r;
      v = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 19))
        0:       r = 0;
        1, 2:    r = $urandom_range(256, 511);
        3, 4:    r = 1;
        5:       r = $urandom_range(13, 255);
        default: r = $urandom_range(1, 12);
      endcase
      m_step(v, r);
      cyc(v, r);
      chk_all($sformatf("rnd%0d", i), m_ratio, m_ratio != 1, m_phase(), !m_pend, m_upd, m_err);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
